// File: rtl/seq_divider.sv
// Sequential restoring divider: one quotient bit per clock, start/busy/done handshake.
// Define DIV_SIGNED_EN for a two's-complement build; otherwise operands are unsigned.
module seq_divider #(
   parameter int unsigned WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start_i,
   input  logic [WIDTH-1:0] dividend_i,
   input  logic [WIDTH-1:0] divisor_i,
   output logic [WIDTH-1:0] quotient_o,
   output logic [WIDTH-1:0] remainder_o,
   output logic             busy_o,
   output logic             done_o,
   output logic             div_by_zero_o,
   output logic             overflow_o
);

`ifdef DIV_SIGNED_EN
   localparam bit SignedEn = 1'b1;
`else
   localparam bit SignedEn = 1'b0;
`endif

   localparam int unsigned CntW = $clog2(WIDTH);
   localparam logic [WIDTH-1:0] MinVal = {1'b1, {(WIDTH-1){1'b0}}};

   typedef enum logic [1:0] {StIdle, StRun, StFix} state_e;

   state_e            state_q, state_d;
   logic [CntW-1:0]   cnt_q, cnt_d;
   logic [WIDTH:0]    prem_q, prem_d;
   logic [WIDTH-1:0]  dvd_q, dvd_d;
   logic [WIDTH-1:0]  dvs_q, dvs_d;
   logic [WIDTH-1:0]  raw_q, raw_d;
   logic              sa_q, sa_d, sb_q, sb_d;
   logic [WIDTH-1:0]  quot_q, quot_d, rem_q, rem_d;
   logic              busy_q, busy_d, done_q, done_d, dbz_q, dbz_d, ovf_q, ovf_d;

   logic [WIDTH+1:0]  shifted;
   logic [WIDTH:0]    diff;
   logic              ge;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      prem_d  = prem_q;
      dvd_d   = dvd_q;
      dvs_d   = dvs_q;
      raw_d   = raw_q;
      sa_d    = sa_q;
      sb_d    = sb_q;
      quot_d  = quot_q;
      rem_d   = rem_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      dbz_d   = dbz_q;
      ovf_d   = ovf_q;

      shifted = {prem_q, dvd_q[WIDTH-1]};
      ge      = shifted >= {2'b00, dvs_q};
      diff    = shifted[WIDTH:0] - {1'b0, dvs_q};

      unique case (state_q)
         StIdle: begin
            if (start_i) begin
               sa_d    = SignedEn & dividend_i[WIDTH-1];
               sb_d    = SignedEn & divisor_i[WIDTH-1];
               raw_d   = dividend_i;
               dvd_d   = sa_d ? -dividend_i : dividend_i;
               dvs_d   = sb_d ? -divisor_i : divisor_i;
               prem_d  = '0;
               cnt_d   = '0;
               busy_d  = 1'b1;
               state_d = StRun;
            end
         end
         StRun: begin
            prem_d = ge ? diff : shifted[WIDTH:0];
            dvd_d  = {dvd_q[WIDTH-2:0], ge};
            cnt_d  = cnt_q + CntW'(1);
            if (cnt_q == CntW'(WIDTH - 1)) begin
               state_d = StFix;
            end
         end
         StFix: begin
            dbz_d = 1'b0;
            ovf_d = 1'b0;
            if (dvs_q == '0) begin
               quot_d = '1;
               rem_d  = raw_q;
               dbz_d  = 1'b1;
            end else if (SignedEn && sa_q && sb_q && dvs_q == WIDTH'(1) && raw_q == MinVal) begin
               // Magnitude 2^(WIDTH-1) does not fit as a positive result; report MIN.
               quot_d = MinVal;
               rem_d  = '0;
               ovf_d  = 1'b1;
            end else begin
               quot_d = (sa_q ^ sb_q) ? -dvd_q : dvd_q;
               rem_d  = sa_q ? -prem_q[WIDTH-1:0] : prem_q[WIDTH-1:0];
            end
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         prem_q  <= '0;
         dvd_q   <= '0;
         dvs_q   <= '0;
         raw_q   <= '0;
         sa_q    <= 1'b0;
         sb_q    <= 1'b0;
         quot_q  <= '0;
         rem_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         dbz_q   <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         prem_q  <= prem_d;
         dvd_q   <= dvd_d;
         dvs_q   <= dvs_d;
         raw_q   <= raw_d;
         sa_q    <= sa_d;
         sb_q    <= sb_d;
         quot_q  <= quot_d;
         rem_q   <= rem_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         dbz_q   <= dbz_d;
         ovf_q   <= ovf_d;
      end
   end

   assign quotient_o    = quot_q;
   assign remainder_o   = rem_q;
   assign busy_o        = busy_q;
   assign done_o        = done_q;
   assign div_by_zero_o = dbz_q;
   assign overflow_o    = ovf_q;

endmodule

// File: tb/tb_seq_divider.sv
// Randomised bench for seq_divider against an arithmetic reference model (WIDTH=4).
// Follows the DUT build: define DIV_SIGNED_EN for both to check the signed variant.
module tb_seq_divider;

   localparam int W = 4;

   logic         clk;
   logic         rst;
   logic         start;
   logic [W-1:0] dividend, divisor;
   logic [W-1:0] quotient, remainder;
   logic         busy, done, div_by_zero, overflow;

   int n_cmp = 0;
   int n_bad = 0;
   bit chk_en = 1'b0;

   seq_divider #(.WIDTH(W)) dut (
      .clk           (clk),
      .rst           (rst),
      .start_i       (start),
      .dividend_i    (dividend),
      .divisor_i     (divisor),
      .quotient_o    (quotient),
      .remainder_o   (remainder),
      .busy_o        (busy),
      .done_o        (done),
      .div_by_zero_o (div_by_zero),
      .overflow_o    (overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Result packed as {overflow, div_by_zero, quotient, remainder}.
   function automatic logic [2*W+1:0] ref_div(input logic [W-1:0] a, input logic [W-1:0] b);
      logic [W-1:0] q, r;
      logic z, o;
      z = (b == '0);
      o = 1'b0;
      if (z) begin
         q = '1;
         r = a;
      end else begin
`ifdef DIV_SIGNED_EN
         int sa, sb;
         sa = int'($signed(a));
         sb = int'($signed(b));
         if (sa == -(2 ** (W - 1)) && sb == -1) begin
            q = a;
            r = '0;
            o = 1'b1;
         end else begin
            q = W'(sa / sb);
            r = W'(sa % sb);
         end
`else
         q = a / b;
         r = a % b;
`endif
      end
      return {o, z, q, r};
   endfunction

   task automatic check(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Transaction-level model: accept when idle, deliver result W+1 edges later.
   logic         m_busy, m_done;
   int           m_left;
   logic [W-1:0] m_a, m_b;
   logic [2*W+1:0] m_res;

   always @(posedge clk) begin
      if (rst) begin
         m_busy <= 1'b0;
         m_done <= 1'b0;
         m_left <= 0;
         m_res  <= '0;
      end else begin
         m_done <= 1'b0;
         if (!m_busy) begin
            if (start) begin
               m_busy <= 1'b1;
               m_left <= W;
               m_a    <= dividend;
               m_b    <= divisor;
            end
         end else if (m_left > 0) begin
            m_left <= m_left - 1;
         end else begin
            m_res  <= ref_div(m_a, m_b);
            m_busy <= 1'b0;
            m_done <= 1'b1;
         end
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         check("quotient", int'(quotient), int'(m_res[2*W-1:W]));
         check("remainder", int'(remainder), int'(m_res[W-1:0]));
         check("div_by_zero", int'(div_by_zero), int'(m_res[2*W]));
         check("overflow", int'(overflow), int'(m_res[2*W+1]));
         check("busy", int'(busy), int'(m_busy));
         check("done", int'(done), int'(m_done));
      end
   end

   // Called at a negedge; returns at the negedge where done is high.
   task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] eq, input logic [W-1:0] er,
                         input logic ez, input logic eo, input bit repulse);
      int k;
      start    = 1'b1;
      dividend = a;
      divisor  = b;
      @(negedge clk);
      start    = 1'b0;
      dividend = W'($urandom);
      divisor  = W'($urandom);
      k = 0;
      while (!done && k < 20) begin
         if (repulse && k == 1) begin
            start    = 1'b1;
            dividend = 4'd9;
            divisor  = 4'd9;
         end else begin
            start = 1'b0;
         end
         @(negedge clk);
         k++;
      end
      start = 1'b0;
      check("latency", k, W + 1);
      check("op_quotient", int'(quotient), int'(eq));
      check("op_remainder", int'(remainder), int'(er));
      check("op_div_by_zero", int'(div_by_zero), int'(ez));
      check("op_overflow", int'(overflow), int'(eo));
   endtask

   initial begin
      rst      = 1'b1;
      start    = 1'b0;
      dividend = '0;
      divisor  = '0;
      repeat (2) @(negedge clk);
      check("rst_quotient", int'(quotient), 0);
      check("rst_remainder", int'(remainder), 0);
      check("rst_busy", int'(busy), 0);
      check("rst_done", int'(done), 0);
      check("rst_div_by_zero", int'(div_by_zero), 0);
      check("rst_overflow", int'(overflow), 0);
      chk_en = 1'b1;

      // Reset beats a simultaneous start.
      start    = 1'b1;
      dividend = 4'd7;
      divisor  = 4'd2;
      @(negedge clk);
      check("rst_wins_busy", int'(busy), 0);
      rst   = 1'b0;
      start = 1'b0;
      @(negedge clk);

`ifdef DIV_SIGNED_EN
      check("model_pin_a", int'(ref_div(4'b1001, 4'd2)), int'({2'b00, 4'b1101, 4'b1111}));
      check("model_pin_b", int'(ref_div(4'b1000, 4'b1111)), int'({2'b10, 4'b1000, 4'b0000}));
      run_op(4'd7, 4'd2, 4'd3, 4'd1, 1'b0, 1'b0, 1'b0);
      run_op(4'b1001, 4'd2, 4'b1101, 4'b1111, 1'b0, 1'b0, 1'b0);
      run_op(4'd7, 4'b1110, 4'b1101, 4'd1, 1'b0, 1'b0, 1'b0);
      run_op(4'b1001, 4'b1110, 4'd3, 4'b1111, 1'b0, 1'b0, 1'b0);
      run_op(4'b1000, 4'b1111, 4'b1000, 4'd0, 1'b0, 1'b1, 1'b0);
`else
      check("model_pin_a", int'(ref_div(4'd13, 4'd3)), int'({2'b00, 4'd4, 4'd1}));
      check("model_pin_b", int'(ref_div(4'd9, 4'd0)), int'({2'b01, 4'd15, 4'd9}));
      run_op(4'd7, 4'd2, 4'd3, 4'd1, 1'b0, 1'b0, 1'b0);
      run_op(4'd15, 4'd4, 4'd3, 4'd3, 1'b0, 1'b0, 1'b1);
`endif
      run_op(4'd5, 4'd0, 4'b1111, 4'd5, 1'b1, 1'b0, 1'b0);
      run_op(4'd6, 4'd3, 4'd2, 4'd0, 1'b0, 1'b0, 1'b0);

      // Abort 9 / 2 at RUN step 2.
      start    = 1'b1;
      dividend = 4'd9;
      divisor  = 4'd2;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("abort_quotient", int'(quotient), 0);
      check("abort_remainder", int'(remainder), 0);
      check("abort_busy", int'(busy), 0);
      repeat (W + 3) begin
         @(negedge clk);
         check("abort_no_done", int'(done), 0);
      end
`ifdef DIV_SIGNED_EN
      run_op(4'd9, 4'd2, 4'b1101, 4'b1111, 1'b0, 1'b0, 1'b0);
`else
      run_op(4'd9, 4'd2, 4'd4, 4'd1, 1'b0, 1'b0, 1'b0);
`endif

      // Random traffic: starts while busy, back-to-back, zero divisors, stray resets.
      for (int i = 0; i < 3000; i++) begin
         rst      = ($urandom_range(0, 299) == 0);
         start    = ($urandom_range(0, 3) == 0);
         dividend = W'($urandom);
         divisor  = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
         if ($urandom_range(0, 15) == 0) begin
            dividend = 4'b1000;
            divisor  = 4'b1111;
         end
         @(negedge clk);
      end
      rst   = 1'b0;
      start = 1'b0;
      repeat (W + 4) @(negedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
